c16_sdram_arb: RTL

C16_SDRAM_ARB -- requirements
Module: c16_sdram_arb

---
 rtl/c16_sdram_pkg.sv | 27 ++
 rtl/c16_sdram_arb_if.sv | 24 ++
 rtl/c16_sdram_refresh_timer.sv | 66 ++++++
 rtl/c16_sdram_arb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/c16_sdram_pkg.sv
// Shared types and defaults for the C16 SDRAM arbiter.
package c16_sdram_pkg;

    // 24-bit byte address used on every port of the arbiter
    typedef logic [23:0] addr_t;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        C16  = 2'd1,
        DL   = 2'd2,
        REF  = 2'd3
    } arb_state_t;

    // Command fields captured in a pending slot and presented to the controller
    typedef struct packed {
        logic       we;
        addr_t      addr;
        logic [7:0] din;
    } mem_cmd_t;

    // About 7.8 us at 28.375 MHz between refresh requests
    localparam int unsigned REF_INTERVAL_DEF = 32'd220;
    // Cycles a pending refresh may wait before it preempts C16 traffic
    localparam int unsigned REF_DEFER_DEF    = 32'd32;

endpackage

// File: rtl/c16_sdram_arb_if.sv
// Command/response bus between the arbiter and the SDRAM controller.
interface c16_sdram_arb_if;
    import c16_sdram_pkg::*;

    logic       mem_req;
    logic       mem_refresh;
    logic       mem_we;
    addr_t      mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic       mem_ready;

    // Arbiter side
    modport master (
        output mem_req, mem_refresh, mem_we, mem_addr, mem_din,
        input  mem_dout, mem_ready
    );

    // SDRAM controller side
    modport slave (
        input  mem_req, mem_refresh, mem_we, mem_addr, mem_din,
        output mem_dout, mem_ready
    );
endinterface

// File: rtl/c16_sdram_refresh_timer.sv
// Refresh interval counter with pending flag and age tracking.
// ref_urgent rises once a pending refresh has waited REF_DEFER cycles.
module c16_sdram_refresh_timer
    import c16_sdram_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int unsigned REF_DEFER    = REF_DEFER_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ref_clr,
    output logic ref_pend,
    output logic ref_urgent
);
    localparam int unsigned CNT_W = $clog2(REF_INTERVAL);
    localparam int unsigned AGE_W = $clog2(REF_DEFER + 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_INTERVAL - 32'd1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(REF_DEFER);

    logic [CNT_W-1:0] cnt_r;
    logic [AGE_W-1:0] age_r;
    logic             ref_pend_r;
    logic             wrap_s;

    assign wrap_s = (cnt_r == CNT_LAST);

    // Free-running interval counter, independent of when refreshes are serviced
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (wrap_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Pending flag: a new interval beats a clear landing in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ref_pend_r <= 1'b0;
        end else if (wrap_s) begin
            ref_pend_r <= 1'b1;
        end else if (ref_clr) begin
            ref_pend_r <= 1'b0;
        end else begin
            ref_pend_r <= ref_pend_r;
        end
    end

    // Age of the pending refresh, saturating at REF_DEFER
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            age_r <= '0;
        end else if (ref_clr) begin
            age_r <= '0;
        end else if (ref_pend_r && (age_r != AGE_MAX)) begin
            age_r <= age_r + AGE_W'(1);
        end else begin
            age_r <= age_r;
        end
    end

    assign ref_pend   = ref_pend_r;
    assign ref_urgent = ref_pend_r && (age_r == AGE_MAX);
endmodule

// File: rtl/c16_sdram_arb.sv
// SDRAM arbiter for the C16 core: C16 bus, ROM/cart download and auto-refresh.
// Optional download port enabled by defining C16_SDRAM_ARB_DL_EN.
module c16_sdram_arb
    import c16_sdram_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int unsigned REF_DEFER    = REF_DEFER_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       c16_req,
    input  logic       c16_we,
    input  addr_t      c16_addr,
    input  logic [7:0] c16_din,
    output logic [7:0] c16_dout,
    output logic       c16_ack,
    input  logic       dl_req,
    input  addr_t      dl_addr,
    input  logic [7:0] dl_din,
    output logic       dl_ack,
    c16_sdram_arb_if.master mem
);
    arb_state_t state_r, state_s;
    logic       grant_s, grant_ref_s;
    mem_cmd_t   grant_cmd_s;
    logic       mem_req_r, mem_refresh_r;
    mem_cmd_t   mem_cmd_r;
    logic       c16_pend_r, c16_done_s, c16_avail_s;
    mem_cmd_t   c16_cmd_r, c16_cmd_s;
    logic [7:0] c16_dout_r;
    logic       ref_pend_s, ref_urgent_s, ref_clr_s;

    assign c16_done_s  = (state_r == C16) && mem.mem_ready;
    assign ref_clr_s   = (state_r == REF) && mem.mem_ready;
    // A request strobed while IDLE is granted straight from the port fields
    assign c16_avail_s = c16_pend_r || c16_req;
    assign c16_cmd_s   = c16_pend_r ? c16_cmd_r : {c16_we, c16_addr, c16_din};

    c16_sdram_refresh_timer #(
        .REF_INTERVAL(REF_INTERVAL),
        .REF_DEFER   (REF_DEFER)
    ) u_refresh_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .ref_clr   (ref_clr_s),
        .ref_pend  (ref_pend_s),
        .ref_urgent(ref_urgent_s)
    );

`ifdef C16_SDRAM_ARB_DL_EN
    logic     dl_pend_r, dl_done_s, dl_avail_s;
    mem_cmd_t dl_cmd_r, dl_cmd_s;

    assign dl_done_s  = (state_r == DL) && mem.mem_ready;
    assign dl_avail_s = dl_pend_r || dl_req;
    assign dl_cmd_s   = dl_pend_r ? dl_cmd_r : {1'b1, dl_addr, dl_din};
    assign dl_ack     = reset_n && dl_done_s;

    // Download pending slot; a pulse is accepted when the slot is free or freeing now
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dl_pend_r <= 1'b0;
            dl_cmd_r  <= '0;
        end else if (dl_req && (!dl_pend_r || dl_done_s)) begin
            dl_pend_r <= 1'b1;
            dl_cmd_r  <= {1'b1, dl_addr, dl_din};
        end else if (dl_done_s) begin
            dl_pend_r <= 1'b0;
        end else begin
            dl_pend_r <= dl_pend_r;
        end
    end
`else
    logic dl_unused_s;
    assign dl_unused_s = ^{dl_req, dl_addr, dl_din};
    assign dl_ack      = 1'b0;
`endif

    // Next-state and grant selection; priority: urgent refresh, C16, download, refresh
    always_comb begin
        state_s     = state_r;
        grant_s     = 1'b0;
        grant_ref_s = 1'b0;
        grant_cmd_s = '0;
        case (state_r)
            IDLE: begin
                if (ref_urgent_s) begin
                    state_s     = REF;
                    grant_s     = 1'b1;
                    grant_ref_s = 1'b1;
                end else if (c16_avail_s) begin
                    state_s     = C16;
                    grant_s     = 1'b1;
                    grant_cmd_s = c16_cmd_s;
`ifdef C16_SDRAM_ARB_DL_EN
                end else if (dl_avail_s) begin
                    state_s     = DL;
                    grant_s     = 1'b1;
                    grant_cmd_s = dl_cmd_s;
`endif
                end else if (ref_pend_s) begin
                    state_s     = REF;
                    grant_s     = 1'b1;
                    grant_ref_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            C16, DL, REF: begin
                if (mem.mem_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Controller command: one-cycle strobe on grant, fields held until the next grant
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_req_r     <= 1'b0;
            mem_refresh_r <= 1'b0;
            mem_cmd_r     <= '0;
        end else if (grant_s) begin
            mem_req_r     <= 1'b1;
            mem_refresh_r <= grant_ref_s;
            mem_cmd_r     <= grant_cmd_s;
        end else begin
            mem_req_r     <= 1'b0;
            mem_refresh_r <= mem_refresh_r;
            mem_cmd_r     <= mem_cmd_r;
        end
    end

    // C16 pending slot; a pulse is accepted when the slot is free or freeing now
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            c16_pend_r <= 1'b0;
            c16_cmd_r  <= '0;
        end else if (c16_req && (!c16_pend_r || c16_done_s)) begin
            c16_pend_r <= 1'b1;
            c16_cmd_r  <= {c16_we, c16_addr, c16_din};
        end else if (c16_done_s) begin
            c16_pend_r <= 1'b0;
        end else begin
            c16_pend_r <= c16_pend_r;
        end
    end

    // Read data holding register, updated only when a C16 read completes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            c16_dout_r <= 8'h00;
        end else if (c16_done_s && !c16_cmd_r.we) begin
            c16_dout_r <= mem.mem_dout;
        end else begin
            c16_dout_r <= c16_dout_r;
        end
    end

    // Ack coincides with mem_ready; read data is forwarded in that same cycle
    assign c16_ack  = reset_n && c16_done_s;
    assign c16_dout = (c16_ack && !c16_cmd_r.we) ? mem.mem_dout : c16_dout_r;

    assign mem.mem_req     = mem_req_r;
    assign mem.mem_refresh = mem_refresh_r;
    assign mem.mem_we      = mem_cmd_r.we;
    assign mem.mem_addr    = mem_cmd_r.addr;
    assign mem.mem_din     = mem_cmd_r.din;
endmodule
